otp_word_sequencer: RTL and testbench
=====================================

// Module: otp_word_sequencer
// PURPOSE
//  Upstream driver for the 16-bit one-time-pad encrypt/decrypt core. It packs an incoming byte
//  stream into 16-bit words and runs the core's start/done handshake once per word. It then
//  returns each processed word on a valid/ready output stream.
//  It also handles passthrough, odd-length packets, and a core that never answers (timeout).
// PARAMETERS
//  TIMEOUT_CYCLES  64     max cycles in any wait-for-done state before abort; must be >=2
//  PAD_BYTE        8'h00  low byte inserted when a packet ends on an odd byte
//  TO_W            7      width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  reset_n        in   1   synchronous, active-low reset
//  cfg_bypass     in   1   1 = core passthrough; sampled only in IDLE
//  in_byte        in   8   input byte
//  in_valid       in   1   in_byte valid
//  in_last        in   1   in_byte is final byte of packet
//  in_ready       out  1   sequencer accepts in_byte this cycle
//  core_data      out  16  to core input_data; held stable from LOAD until back in IDLE
//  core_start     out  1   to core start
//  core_passthru  out  1   to core passthrough
//  core_result    in   16  from core output_data
//  core_done      in   1   from core done
//  out_word       out  16  processed word
//  out_last       out  1   word ends packet
//  out_valid      out  1   out_word valid
//  out_ready      in   1   downstream accepts out_word
//  err_timeout    out  1   sticky; set on abort; cleared only by reset
// BEHAVIOUR
//  Reset (reset_n=0 at edge), values from the next cycle:
//   - all outputs 0 (core_data=16'h0000, in_ready=0, err_timeout=0);
//   - byte phase = high; timeout counter = 0; state = IDLE.
//   - Reset mid-operation abandons the word; core_start drops on the same edge.
//  Byte packing:
//   - in_ready=1 only in state IDLE. Transfer = in_valid & in_ready.
//   - 1st byte -> core_data[15:8]; 2nd byte -> core_data[7:0]. Big-endian.
//   - in_last on a 1st byte: core_data[7:0]=PAD_BYTE, last flag set, go to LOAD.
//   - Otherwise the 2nd byte's transfer moves to LOAD; last flag = in_last of that byte.
//   - On entry to LOAD, core_passthru := cfg_bypass; it holds until the next LOAD.
//  FSM, one transition per clock:
//   IDLE    -> LOAD when a word completes (see Byte packing).
//   LOAD    -> 1 cycle, core_start=0, lets core_data settle.
//             bypass? -> CAPTURE : ARM.
//   ARM     -> core_start=1; wait for core_done==0 (core acknowledged) -> BUSY.
//   BUSY    -> core_start=1; wait for core_done==1 -> CAPTURE.
//   CAPTURE -> core_start=0; out_word := core_result; out_last := last flag;
//             out_valid := 1 -> OUT.
//   OUT     -> hold out_word/out_last/out_valid stable.
//             out_valid & out_ready -> out_valid=0, byte phase=high -> IDLE.
//   Start pulse per word: core_start rises in ARM and falls in CAPTURE. The core needs start
//   to fall before it accepts another transaction; core_start therefore stays low for at least
//   LOAD+IDLE (>=2 cycles) between words.
//  Latency:
//   - core mode: last input byte -> out_valid = 4 + (ARM wait) + (BUSY wait) cycles.
//   - bypass: last input byte -> out_valid = 3 cycles (IDLE->LOAD->CAPTURE->OUT).
//  Timeout:
//   - Counter clears on entry to ARM and BUSY; increments each cycle spent there.
//   - Reaching TIMEOUT_CYCLES in ARM or BUSY:
//     core_start=0, err_timeout=1, word dropped (no out_valid), -> IDLE.
//   - A packet whose last word was dropped gets no out_last. Downstream detects this
//     through err_timeout.
//  Boundaries:
//   - cfg_bypass changes outside IDLE are ignored for the word in flight.
//   - out_ready already high on entry to OUT: 1-cycle OUT.
//   - Back-pressure holds the FSM in OUT; in_ready stays 0.
//   - core_done already 0 on entry to ARM (stale): taken as the acknowledgement.
// TESTING
//  1 Core mode, key 16'h3327: bytes 12,34 (last) -> start high in ARM, done 1->0->1.
//    Expect out_word=16'h2113, out_last=1, err_timeout=0.
//  2 Odd packet: single byte AB with in_last -> core_data=16'hAB00.
//    Expect out_word=16'h9827, out_last=1.
//  3 Bypass: cfg_bypass=1, bytes DE,AD -> core_start stays 0.
//    Expect out_word=16'hDEAD exactly 3 cycles after the 2nd byte.
//  4 Back-pressure: out_ready=0 for 10 cycles -> out_word stable, in_ready=0.
//    Releasing out_ready returns to IDLE and next bytes are accepted.
//  5 Timeout: core_done stuck 1 -> after 64 cycles in ARM: core_start=0, err_timeout=1,
//    no out_valid, FSM back in IDLE.
//  6 Reset in BUSY: reset_n=0 for one edge -> core_start=0, out_valid=0, in_ready=0.
//    A fresh 2-byte packet then completes normally.

Source files
------------

// File: rtl/otp_word_sequencer.sv
// Byte-to-word packer and start/done handshake driver for the 16-bit one-time-pad core.
// Each packed word runs one core transaction, or skips the core in passthrough mode, then leaves on a valid/ready stream.
module otp_word_sequencer #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter int         TO_W           = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_bypass,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] core_data,
    output logic        core_start,
    output logic        core_passthru,
    input  logic [15:0] core_result,
    input  logic        core_done,
    output logic [15:0] out_word,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ARM     = 3'd2,
        S_BUSY    = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              phase_lo_q, phase_lo_d;
    logic              last_q, last_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [15:0]       core_data_q, core_data_d;
    logic              core_start_q, core_start_d;
    logic              core_passthru_q, core_passthru_d;
    logic [15:0]       out_word_q, out_word_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              err_timeout_q, err_timeout_d;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d         = state_q;
        phase_lo_d      = phase_lo_q;
        last_d          = last_q;
        to_cnt_d        = to_cnt_q;
        core_data_d     = core_data_q;
        core_passthru_d = core_passthru_q;
        out_word_d      = out_word_q;
        out_last_d      = out_last_q;
        out_valid_d     = out_valid_q;
        err_timeout_d   = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (!phase_lo_q) begin
                        core_data_d[15:8] = in_byte;
                        if (in_last) begin
                            core_data_d[7:0] = PAD_BYTE;
                            last_d           = 1'b1;
                            core_passthru_d  = cfg_bypass;
                            state_d          = S_LOAD;
                        end else begin
                            phase_lo_d = 1'b1;
                        end
                    end else begin
                        core_data_d[7:0] = in_byte;
                        last_d           = in_last;
                        phase_lo_d       = 1'b0;
                        core_passthru_d  = cfg_bypass;
                        state_d          = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                to_cnt_d = '0;
                if (core_passthru_q) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_ARM;
                end
            end
            // A done that is already low on entry counts as the acknowledgement.
            S_ARM: begin
                if (!core_done) begin
                    to_cnt_d = '0;
                    state_d  = S_BUSY;
                end else if (to_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    phase_lo_d    = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_BUSY: begin
                if (core_done) begin
                    state_d = S_CAPTURE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    phase_lo_d    = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_CAPTURE: begin
                out_word_d  = core_result;
                out_last_d  = last_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    phase_lo_d  = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Start is high exactly while waiting on the core, so it is low in LOAD/CAPTURE/IDLE.
        in_ready_d   = (state_d == S_IDLE);
        core_start_d = (state_d == S_ARM) || (state_d == S_BUSY);
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            phase_lo_q      <= 1'b0;
            last_q          <= 1'b0;
            to_cnt_q        <= '0;
            core_data_q     <= 16'h0000;
            core_start_q    <= 1'b0;
            core_passthru_q <= 1'b0;
            out_word_q      <= 16'h0000;
            out_last_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_lo_q      <= phase_lo_d;
            last_q          <= last_d;
            to_cnt_q        <= to_cnt_d;
            core_data_q     <= core_data_d;
            core_start_q    <= core_start_d;
            core_passthru_q <= core_passthru_d;
            out_word_q      <= out_word_d;
            out_last_q      <= out_last_d;
            out_valid_q     <= out_valid_d;
            in_ready_q      <= in_ready_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign core_data     = core_data_q;
    assign core_start    = core_start_q;
    assign core_passthru = core_passthru_q;
    assign out_word      = out_word_q;
    assign out_last      = out_last_q;
    assign out_valid     = out_valid_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_otp_word_sequencer.sv
// Directed bench for otp_word_sequencer: a simple XOR-key core model, a packet-level scoreboard
// of expected words, and literal checks for the scenarios of interest.
module tb_otp_word_sequencer;

    localparam logic [15:0] KEY = 16'h3327;
    localparam logic [7:0]  PAD = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_bypass;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] core_data;
    logic        core_start;
    logic        core_passthru;
    logic [15:0] core_result;
    logic        core_done = 1'b1;
    logic [15:0] out_word;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err_timeout;

    always #5 clk = ~clk;

    otp_word_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cfg_bypass(cfg_bypass),
        .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .core_data(core_data), .core_start(core_start), .core_passthru(core_passthru),
        .core_result(core_result), .core_done(core_done),
        .out_word(out_word), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .err_timeout(err_timeout)
    );

    // Core model: XOR with KEY (or passthrough); done drops after start, rises busy_len cycles later.
    logic core_stuck = 1'b0;
    int   busy_len   = 3;
    logic busy_flag  = 1'b0;
    int   ccnt       = 0;
    assign core_result = core_passthru ? core_data : (core_data ^ KEY);

    always @(posedge clk) begin
        if (core_stuck) begin
            core_done <= 1'b1;
        end else if (!core_start) begin
            busy_flag <= 1'b0;
        end else if (!busy_flag) begin
            busy_flag <= 1'b1;
            core_done <= 1'b0;
            ccnt      <= busy_len;
        end else if (ccnt > 0) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1) core_done <= 1'b1;
        end
    end

    typedef struct packed {
        logic [15:0] w;
        logic        l;
    } exp_t;
    exp_t expq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Scoreboard compare: every accepted output word against the packet model.
    logic [15:0] prev_word;
    logic        prev_last;
    logic        prev_hold = 1'b0;
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (reset_n === 1'b1) begin
            if (out_valid) begin
                chk("in_ready_in_out", in_ready, 0);
                if (prev_hold) begin
                    chk("hold_word", out_word, prev_word);
                    chk("hold_last", out_last, prev_last);
                end
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        bound_fail("unexpected_word");
                    end else begin
                        e = expq.pop_front();
                        chk("sb_word", out_word, e.w);
                        chk("sb_last", out_last, e.l);
                    end
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_word = out_word;
                    prev_last = out_last;
                end
            end else begin
                prev_hold = 1'b0;
            end
            if (core_passthru && core_start) bound_fail("start_in_bypass");
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) bound_fail("in_ready_wait");
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Model: split a packet (bytes MSB-first in data) into big-endian words, pad odd tail.
    task automatic send_packet(input logic [31:0] data, input int n, input bit byp, input bit expect_out);
        exp_t        e;
        logic [7:0]  hi, lo;
        logic [15:0] w;
        for (int i = 0; i < n; i += 2) begin
            hi = data[31-8*i -: 8];
            lo = (i + 1 < n) ? data[31-8*(i+1) -: 8] : PAD;
            w  = {hi, lo};
            if (!byp) w = w ^ KEY;
            e.w = w;
            e.l = (i + 2 >= n);
            if (expect_out) expq.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(data[31-8*i -: 8], (i == n - 1));
        end
    endtask

    task automatic wait_out(input string name, input logic [15:0] ew, input logic el, output logic saw_start);
        int t = 0;
        saw_start = 1'b0;
        while (!out_valid && t < 300) begin
            saw_start |= core_start;
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            bound_fail({name, "_out_valid"});
        end else begin
            chk({name, "_word"}, out_word, ew);
            chk({name, "_last"}, out_last, el);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((out_valid || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (out_valid || !in_ready) bound_fail("return_idle");
    endtask

    initial begin
        logic st;
        int   lat;
        int   hi_cnt;
        int   t;
        reset_n = 1'b0; cfg_bypass = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_data", core_data, 16'h0000);
        chk("rst_core_start", core_start, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_out_word", out_word, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // 1: core mode, two bytes
        send_packet(32'h1234_0000, 2, 0, 1);
        wait_out("t1", 16'h2113, 1'b1, st);
        chk("t1_start_seen", st, 1);
        chk("t1_err", err_timeout, 0);
        wait_idle();

        // 2: odd packet padded
        send_packet(32'hAB00_0000, 1, 0, 1);
        wait_out("t2", 16'h9827, 1'b1, st);
        chk("t2_core_data", core_data, 16'hAB00);
        wait_idle();

        // 3: bypass; flipping cfg_bypass after the word completes must not matter
        cfg_bypass = 1'b1;
        send_packet(32'hDEAD_0000, 2, 1, 1);
        cfg_bypass = 1'b0;
        lat = 1;
        st  = core_start;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            st |= core_start;
            lat++;
        end
        chk("t3_latency", lat, 3);
        chk("t3_word", out_word, 16'hDEAD);
        chk("t3_no_start", st, 0);
        wait_idle();

        // 4: back-pressure, then a two-word packet
        out_ready = 1'b0;
        send_packet(32'h5AC3_0000, 2, 0, 1);
        wait_out("t4", 16'h69E4, 1'b1, st);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_bp_word", out_word, 16'h69E4);
            chk("t4_bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_idle();
        send_packet(32'h0102_0304, 4, 0, 1);
        wait_out("t4b", 16'h3023, 1'b1, st);
        wait_idle();

        // 5: timeout with done stuck high
        core_stuck = 1'b1;
        send_packet(32'h7788_0000, 2, 0, 0);
        t = 0;
        while (!core_start && t < 50) begin
            @(negedge clk);
            t++;
        end
        hi_cnt = 0;
        while (core_start && hi_cnt < 200) begin
            hi_cnt++;
            @(negedge clk);
        end
        chk("t5_arm_cycles", hi_cnt, 64);
        chk("t5_err", err_timeout, 1);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        core_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", err_timeout, 1);

        // 6: reset while BUSY, then a fresh packet completes
        busy_len = 30;
        send_packet(32'h1122_0000, 2, 0, 0);
        t = 0;
        while (!(core_start && !core_done) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!(core_start && !core_done)) bound_fail("t6_reach_busy");
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6_core_start", core_start, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 0);
        chk("t6_err", err_timeout, 0);
        busy_len = 3;
        @(negedge clk);
        send_packet(32'h9ABC_0000, 2, 0, 1);
        wait_out("t6", 16'hA99B, 1'b1, st);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
